// File: rtl/ndp_stream_sequencer.sv
// Control sequencer for the NDP datapath: streams a frame into a bank ring, zero-pads the
// final tile, hands filled banks to compute in order, then drains the result vector as a stream.
module ndp_stream_sequencer #(
  parameter int IN_W           = 32,
  parameter int OUT_W          = 32,
  parameter int WORDS_PER_TILE = 34,
  parameter int NUM_BANKS      = 2,
  parameter int RES_BITS       = 1024,
  parameter int ADDR_BITS      = $clog2(WORDS_PER_TILE),
  parameter int BANK_BITS      = $clog2(NUM_BANKS)
) (
  input  logic                 axi_aclk,
  input  logic                 axi_aresetn,
  input  logic [IN_W-1:0]      s_axis_tdata,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [OUT_W-1:0]     m_axis_tdata,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 buf_wr_en,
  output logic [BANK_BITS-1:0] buf_wr_bank,
  output logic [ADDR_BITS-1:0] buf_wr_addr,
  output logic [IN_W-1:0]      buf_wr_data,
  output logic                 tile_valid,
  input  logic                 tile_ready,
  output logic [BANK_BITS-1:0] tile_bank,
  output logic                 tile_last,
  input  logic                 tile_done,
  input  logic                 calc_done,
  input  logic [RES_BITS-1:0]  res_data,
  output logic                 ndp_clear,
  output logic [2:0]           dbg_state
);

  localparam int RES_BEATS = RES_BITS / OUT_W;
  localparam int BEAT_BITS = $clog2(RES_BEATS + 1);
  localparam int CNT_BITS  = BANK_BITS + 1;

  localparam logic [ADDR_BITS-1:0] LAST_WORD = ADDR_BITS'(WORDS_PER_TILE - 1);
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(RES_BEATS - 1);
  localparam logic [CNT_BITS-1:0]  BANKS_CNT = CNT_BITS'(NUM_BANKS);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INGEST    = 3'd1;
  localparam logic [2:0] ST_PAD       = 3'd2;
  localparam logic [2:0] ST_WAIT_CALC = 3'd3;
  localparam logic [2:0] ST_DRAIN     = 3'd4;

  logic [2:0]           state;
  logic [BANK_BITS-1:0] wr_ptr;
  logic [BANK_BITS-1:0] iss_ptr;
  logic [BANK_BITS-1:0] last_bank;
  logic                 last_marked;
  logic                 last_issued;
  logic [ADDR_BITS-1:0] word_cnt;
  logic [CNT_BITS-1:0]  filled_cnt;
  logic [CNT_BITS-1:0]  pend_cnt;
  logic [RES_BITS-1:0]  res_sr;
  logic [BEAT_BITS-1:0] beat_cnt;

  logic in_hs;
  logic word_end;
  logic fill;
  logic issue;
  logic release_ok;
  logic out_hs;

  // Every channel (s_axis, tile, m_axis) transfers on a cycle where valid and ready are both
  // high at the rising edge; valid and its payload never change while valid & !ready.
  always_comb begin
    in_hs      = s_axis_tvalid && s_axis_tready;
    word_end   = (word_cnt == LAST_WORD);
    fill       = (in_hs && word_end) || ((state == ST_PAD) && word_end);
    issue      = tile_valid && tile_ready;
    // filled_cnt - pend_cnt is the number of issued banks not yet released
    release_ok = tile_done && (filled_cnt != pend_cnt);
    out_hs     = m_axis_tvalid && m_axis_tready;
  end

  assign s_axis_tready = (state == ST_INGEST) && (filled_cnt < BANKS_CNT);
  assign buf_wr_en     = in_hs || (state == ST_PAD);
  assign buf_wr_bank   = wr_ptr;
  assign buf_wr_addr   = word_cnt;
  assign buf_wr_data   = in_hs ? s_axis_tdata : '0;

  assign tile_valid    = (pend_cnt != '0);
  assign tile_bank     = iss_ptr;
  assign tile_last     = tile_valid && last_marked && (iss_ptr == last_bank);

  assign m_axis_tvalid = (state == ST_DRAIN);
  assign m_axis_tdata  = res_sr[OUT_W-1:0];
  assign m_axis_tlast  = (state == ST_DRAIN) && (beat_cnt == LAST_BEAT);

  // Gated by reset so the clear pulse cannot appear while reset holds the FSM in IDLE
  assign ndp_clear     = (state == ST_IDLE) && axi_aresetn;
  assign dbg_state     = state;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state       <= ST_IDLE;
      wr_ptr      <= '0;
      iss_ptr     <= '0;
      last_bank   <= '0;
      last_marked <= 1'b0;
      last_issued <= 1'b0;
      word_cnt    <= '0;
      filled_cnt  <= '0;
      pend_cnt    <= '0;
      res_sr      <= '0;
      beat_cnt    <= '0;
    end else begin
      if (fill) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (issue) begin
        iss_ptr <= iss_ptr + 1'b1;
        if (tile_last) begin
          last_issued <= 1'b1;
        end
      end

      case ({fill, release_ok})
        2'b10:   filled_cnt <= filled_cnt + 1'b1;
        2'b01:   filled_cnt <= filled_cnt - 1'b1;
        default: filled_cnt <= filled_cnt;
      endcase

      case ({fill, issue})
        2'b10:   pend_cnt <= pend_cnt + 1'b1;
        2'b01:   pend_cnt <= pend_cnt - 1'b1;
        default: pend_cnt <= pend_cnt;
      endcase

      case (state)
        ST_IDLE: begin
          // Each frame restarts the ring at bank 0; the ring is empty whenever IDLE is reached
          wr_ptr      <= '0;
          iss_ptr     <= '0;
          word_cnt    <= '0;
          last_marked <= 1'b0;
          last_issued <= 1'b0;
          beat_cnt    <= '0;
          state       <= ST_INGEST;
        end

        ST_INGEST: begin
          if (in_hs) begin
            word_cnt <= word_end ? '0 : word_cnt + 1'b1;
            if (s_axis_tlast) begin
              if (word_end) begin
                last_marked <= 1'b1;
                last_bank   <= wr_ptr;
                state       <= ST_WAIT_CALC;
              end else begin
                state <= ST_PAD;
              end
            end
          end
        end

        ST_PAD: begin
          if (word_end) begin
            word_cnt    <= '0;
            last_marked <= 1'b1;
            last_bank   <= wr_ptr;
            state       <= ST_WAIT_CALC;
          end else begin
            word_cnt <= word_cnt + 1'b1;
          end
        end

        ST_WAIT_CALC: begin
          if (last_issued && (filled_cnt == '0) && calc_done) begin
            res_sr   <= res_data;
            beat_cnt <= '0;
            state    <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (out_hs) begin
            res_sr   <= res_sr >> OUT_W;
            beat_cnt <= beat_cnt + 1'b1;
            if (m_axis_tlast) begin
              state <= ST_IDLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ndp_stream_sequencer.sv
// Bench for ndp_stream_sequencer: random frames driven into a default-sized instance and a
// wide/4-bank instance, with queued expectations popped by output monitors.
`timescale 1ns/1ps
module tb_ndp_stream_sequencer;

  localparam int IN_W      = 32;
  localparam int OUT_W     = 32;
  localparam int WPT       = 34;
  localparam int NB        = 2;
  localparam int RES_BITS  = 1024;
  localparam int AB        = 6;
  localparam int BB        = 1;
  localparam int RES_BEATS = RES_BITS / OUT_W;
  localparam int WR_W      = 1 + BB + AB + IN_W;
  localparam int TL_W      = 1 + BB;
  localparam int BT_W      = 1 + OUT_W;

  localparam int B_OUT_W   = 64;
  localparam int B_NB      = 4;
  localparam int B_WPT     = 8;
  localparam int B_AB      = 3;
  localparam int B_BB      = 2;
  localparam int B_BEATS   = RES_BITS / B_OUT_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance signals
  logic [IN_W-1:0]     s_tdata = '0;
  logic                s_tlast = 1'b0;
  logic                s_tvalid = 1'b0;
  logic                s_tready;
  logic [OUT_W-1:0]    m_tdata;
  logic                m_tlast;
  logic                m_tvalid;
  logic                m_tready = 1'b1;
  logic                wr_en;
  logic [BB-1:0]       wr_bank;
  logic [AB-1:0]       wr_addr;
  logic [IN_W-1:0]     wr_data;
  logic                tile_valid;
  logic                tile_ready = 1'b0;
  logic [BB-1:0]       tile_bank;
  logic                tile_last;
  logic                tile_done = 1'b0;
  logic                calc_done = 1'b0;
  logic [RES_BITS-1:0] res_data = '0;
  logic                ndp_clear;
  logic [2:0]          dbg_state;

  ndp_stream_sequencer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .WORDS_PER_TILE(WPT), .NUM_BANKS(NB), .RES_BITS(RES_BITS)
  ) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .buf_wr_en(wr_en), .buf_wr_bank(wr_bank), .buf_wr_addr(wr_addr), .buf_wr_data(wr_data),
    .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_bank(tile_bank), .tile_last(tile_last),
    .tile_done(tile_done), .calc_done(calc_done), .res_data(res_data),
    .ndp_clear(ndp_clear), .dbg_state(dbg_state)
  );

  // wide instance signals (compute side always accepts and releases immediately)
  logic [IN_W-1:0]     b_s_tdata = '0;
  logic                b_s_tlast = 1'b0;
  logic                b_s_tvalid = 1'b0;
  logic                b_s_tready;
  logic [B_OUT_W-1:0]  b_m_tdata;
  logic                b_m_tlast;
  logic                b_m_tvalid;
  logic                b_m_tready = 1'b1;
  logic                b_wr_en;
  logic [B_BB-1:0]     b_wr_bank;
  logic [B_AB-1:0]     b_wr_addr;
  logic [IN_W-1:0]     b_wr_data;
  logic                b_tile_valid;
  logic                b_tile_ready = 1'b1;
  logic [B_BB-1:0]     b_tile_bank;
  logic                b_tile_last;
  logic                b_tile_done = 1'b1;
  logic                b_calc_done = 1'b1;
  logic [RES_BITS-1:0] b_res = '0;
  logic                b_clear;
  logic [2:0]          b_dbg;

  ndp_stream_sequencer #(
    .IN_W(IN_W), .OUT_W(B_OUT_W), .WORDS_PER_TILE(B_WPT), .NUM_BANKS(B_NB), .RES_BITS(RES_BITS)
  ) dut_b (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .s_axis_tdata(b_s_tdata), .s_axis_tlast(b_s_tlast), .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready),
    .m_axis_tdata(b_m_tdata), .m_axis_tlast(b_m_tlast), .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready),
    .buf_wr_en(b_wr_en), .buf_wr_bank(b_wr_bank), .buf_wr_addr(b_wr_addr), .buf_wr_data(b_wr_data),
    .tile_valid(b_tile_valid), .tile_ready(b_tile_ready), .tile_bank(b_tile_bank), .tile_last(b_tile_last),
    .tile_done(b_tile_done), .calc_done(b_calc_done), .res_data(b_res),
    .ndp_clear(b_clear), .dbg_state(b_dbg)
  );

  // scoreboard state
  int tests_run = 0;
  int fails = 0;
  logic [WR_W-1:0]       wr_exp_q[$];
  logic [TL_W-1:0]       tile_exp_q[$];
  logic [BT_W-1:0]       exp_q[$];
  logic [B_BB+B_AB+IN_W-1:0] b_wr_q[$];
  logic [B_OUT_W:0]      b_exp_q[$];
  int due_q[$];
  int cyc = 0;
  int beats_seen = 0;
  int words_accepted = 0;
  int clear_cnt = 0;
  int exp_clears = 0;
  int b_writes = 0;
  logic hold = 1'b0;
  logic rand_tile = 1'b0;
  logic rand_m = 1'b0;
  logic last_seen = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // compute-unit emulation and output-ready generation
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst_n) begin
      tile_done = 1'b0;
      calc_done = 1'b0;
      tile_ready = 1'b0;
    end else begin
      tile_ready = hold ? 1'b0 : (rand_tile ? 1'($urandom_range(1)) : 1'b1);
      m_tready   = rand_m ? 1'($urandom_range(1)) : 1'b1;
      if (!hold && due_q.size() > 0 && due_q[0] <= cyc) begin
        tile_done = 1'b1;
        void'(due_q.pop_front());
      end else begin
        tile_done = 1'b0;
      end
      calc_done = last_seen && (due_q.size() == 0) && !tile_done;
    end
  end

  // monitors: sample away from the rising edge
  logic            prev_t_stall = 1'b0;
  logic [TL_W:0]   prev_tile;
  logic            prev_m_stall = 1'b0;
  logic [BT_W:0]   prev_beat;
  logic [WR_W-1:0] wr_e;
  logic [TL_W-1:0] tl_e;
  logic [BT_W-1:0] bt_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_t_stall = 1'b0;
      prev_m_stall = 1'b0;
    end else begin
      if (wr_en) begin
        if (wr_exp_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          wr_e = wr_exp_q.pop_front();
          chk("wr", {wr_bank, wr_addr, wr_data}, wr_e[WR_W-2:0]);
          if (wr_e[WR_W-1]) chk("pad_tready", s_tready, 0);
        end
      end
      if (prev_t_stall) chk("tile_hold", {tile_valid, tile_last, tile_bank}, prev_tile);
      if (tile_valid && tile_ready) begin
        if (tile_exp_q.size() == 0) chk("tile_unexpected", 1, 0);
        else begin
          tl_e = tile_exp_q.pop_front();
          chk("tile", {tile_last, tile_bank}, tl_e);
        end
        due_q.push_back(cyc + 3);
        if (tile_last) last_seen = 1'b1;
      end
      prev_t_stall = tile_valid && !tile_ready;
      prev_tile    = {tile_valid, tile_last, tile_bank};

      if (prev_m_stall) chk("m_hold", {m_tvalid, m_tlast, m_tdata}, prev_beat);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          bt_e = exp_q.pop_front();
          chk("beat", {m_tlast, m_tdata}, bt_e);
        end
        beats_seen++;
        if (m_tlast) exp_clears++;
      end
      prev_m_stall = m_tvalid && !m_tready;
      prev_beat    = {m_tvalid, m_tlast, m_tdata};

      if (ndp_clear) begin
        clear_cnt++;
        last_seen = 1'b0;
      end

      if (b_wr_en) begin
        b_writes++;
        if (b_wr_q.size() == 0) chk("b_wr_unexpected", 1, 0);
        else chk("b_wr", {b_wr_bank, b_wr_addr, b_wr_data}, b_wr_q.pop_front());
      end
      if (b_m_tvalid && b_m_tready) begin
        if (b_exp_q.size() == 0) chk("b_beat_unexpected", 1, 0);
        else chk("b_beat", {b_m_tlast, b_m_tdata}, b_exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic start_frame(input int n);
    int nt;
    nt = (n + WPT - 1) / WPT;
    for (int k = 0; k < nt; k++) tile_exp_q.push_back({1'(k == nt - 1), BB'(k % NB)});
    for (int w = 0; w < RES_BITS / 32; w++) res_data[w*32 +: 32] = $urandom;
    for (int b = 0; b < RES_BEATS; b++) exp_q.push_back({1'(b == RES_BEATS - 1), res_data[b*OUT_W +: OUT_W]});
    beats_seen = 0;
    words_accepted = 0;
  endtask

  task automatic send_frame(input int n, input int gap_pct);
    logic [IN_W-1:0] d;
    logic ok;
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      if ($urandom_range(99) < gap_pct) begin
        s_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      wr_exp_q.push_back({1'b0, BB'((i / WPT) % NB), AB'(i % WPT), d});
      if (i == n - 1 && (n % WPT) != 0)
        for (int a = n % WPT; a < WPT; a++) wr_exp_q.push_back({1'b1, BB'((i / WPT) % NB), AB'(a), 32'h0});
      s_tdata = d;
      s_tlast = (i == n - 1);
      s_tvalid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 3000 && !ok; c++) begin
        @(negedge clk);
        ok = s_tready;
        @(posedge clk); #1;
      end
      if (!ok) begin
        chk("in_timeout", 0, 1);
        s_tvalid = 1'b0;
        return;
      end
      words_accepted++;
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 8000) begin
      @(negedge clk);
      c++;
    end
    chk("drain_done", exp_q.size(), 0);
    chk("wr_q_empty", wr_exp_q.size(), 0);
    chk("tile_q_empty", tile_exp_q.size(), 0);
    chk("beats_seen", beats_seen, RES_BEATS);
    exp_q.delete();
    wr_exp_q.delete();
    tile_exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int n, input int gap_pct);
    start_frame(n);
    send_frame(n, gap_pct);
    wait_drain();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(tag, {s_tready, m_tvalid, m_tlast, m_tdata, wr_en, wr_bank, wr_addr, wr_data,
              tile_valid, tile_bank, tile_last, ndp_clear, dbg_state}, 0);
  endtask

  task automatic bp_check();
    logic found;
    repeat (200) @(posedge clk);
    @(negedge clk);
    chk("bp_words", words_accepted, 2 * WPT);
    chk("bp_tready_low", s_tready, 0);
    hold = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (tile_done) begin
        found = 1'b1;
        chk("bp_tready_at_done", s_tready, 0);
        @(negedge clk);
        chk("bp_resume", s_tready, 1);
      end
    end
    if (!found) chk("bp_done_seen", 0, 1);
  endtask

  task automatic reset_mid_drain();
    int c;
    start_frame(2 * WPT);
    send_frame(2 * WPT, 0);
    c = 0;
    while (beats_seen < 10 && c < 4000) begin
      @(negedge clk);
      c++;
    end
    chk("pre_reset_beats", beats_seen >= 10, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_drain_reset");
    exp_q.delete();
    wr_exp_q.delete();
    tile_exp_q.delete();
    due_q.delete();
    last_seen = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_clears++;
    @(posedge clk); #1;
  endtask

  task automatic wide_single_word();
    logic [IN_W-1:0] d;
    logic ok;
    int c;
    for (int w = 0; w < RES_BITS / 32; w++) b_res[w*32 +: 32] = $urandom;
    for (int b = 0; b < B_BEATS; b++) b_exp_q.push_back({1'(b == B_BEATS - 1), b_res[b*B_OUT_W +: B_OUT_W]});
    d = $urandom;
    b_wr_q.push_back({B_BB'(0), B_AB'(0), d});
    for (int a = 1; a < B_WPT; a++) b_wr_q.push_back({B_BB'(0), B_AB'(a), 32'h0});
    b_writes = 0;
    b_s_tdata = d;
    b_s_tlast = 1'b1;
    b_s_tvalid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = b_s_tready;
      @(posedge clk); #1;
    end
    chk("b_accept", ok, 1);
    b_s_tvalid = 1'b0;
    b_s_tlast = 1'b0;
    c = 0;
    while (b_exp_q.size() != 0 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("b_drain_done", b_exp_q.size(), 0);
    chk("b_wr_q_empty", b_wr_q.size(), 0);
    chk("b_write_count", b_writes, B_WPT);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s_tdata = 32'hdeadbeef;
    s_tvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    chk("b_reset_state", {b_s_tready, b_m_tvalid, b_wr_en, b_tile_valid, b_clear}, 0);
    s_tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_clears = 1;
    @(posedge clk); #1;

    // two full tiles, no padding
    run_frame(2 * WPT, 0);
    // short final tile padded with zeros
    run_frame(40, 0);
    // compute stalled: ring fills and input backpressures
    start_frame(5 * WPT);
    hold = 1'b1;
    fork
      send_frame(5 * WPT, 0);
      bp_check();
    join
    wait_drain();
    // random gaps, random tile_ready and 50% output backpressure
    rand_tile = 1'b1;
    rand_m = 1'b1;
    for (int f = 0; f < 3; f++) run_frame($urandom_range(150, 1), 30);
    rand_tile = 1'b0;
    rand_m = 1'b0;
    // reset while draining, then a clean frame
    reset_mid_drain();
    run_frame(2 * WPT, 0);
    chk("clear_pulses", clear_cnt, exp_clears);
    // wide output, 4 banks, single-word frame
    wide_single_word();

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
